// File: rtl/alu_share_arb.sv
// Round-robin controller time-sharing one combinational ALU between two valid/ready requesters.
// Define ALU_SHARE_ARB_STATS_EN to add saturating per-requester grant counters (grantCnt0/grantCnt1).
module alu_share_arb #(
    parameter int ALUOpeLen = 4,
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0Valid,
    output logic                 req0Ready,
    input  logic [ALUOpeLen-1:0] req0Ope,
    input  logic [DataWidth-1:0] req0In1,
    input  logic [DataWidth-1:0] req0In2,
    input  logic                 req1Valid,
    output logic                 req1Ready,
    input  logic [ALUOpeLen-1:0] req1Ope,
    input  logic [DataWidth-1:0] req1In1,
    input  logic [DataWidth-1:0] req1In2,
    output logic                 rsp0Valid,
    input  logic                 rsp0Ready,
    output logic                 rsp1Valid,
    input  logic                 rsp1Ready,
    output logic [DataWidth-1:0] rspOut,
    output logic                 rspZero,
    output logic                 rspOverflow,
    output logic [ALUOpeLen-1:0] aluOpe,
    output logic [DataWidth-1:0] aluIn1,
    output logic [DataWidth-1:0] aluIn2,
    input  logic [DataWidth-1:0] aluOut,
    input  logic                 aluZero,
    input  logic                 aluOverflow
`ifdef ALU_SHARE_ARB_STATS_EN
    ,
    output logic [15:0]          grantCnt0,
    output logic [15:0]          grantCnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   last_grant_q, last_grant_d;
    logic [1:0]             rsp_valid_q, rsp_valid_d;
    logic [DataWidth-1:0]   rsp_out_q, rsp_out_d;
    logic                   rsp_zero_q, rsp_zero_d;
    logic                   rsp_ovf_q, rsp_ovf_d;
    logic [ALUOpeLen-1:0]   alu_ope_q, alu_ope_d;
    logic [DataWidth-1:0]   alu_in1_q, alu_in1_d;
    logic [DataWidth-1:0]   alu_in2_q, alu_in2_d;

    logic grant;
    logic idle_ok;
    logic accept;
    logic owner_rsp_ready;

    // A lone requester wins outright; on a tie the one not granted last time wins.
    always_comb begin
        if (req0Valid && req1Valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = req1Valid;
        end
    end

    assign idle_ok   = (state_q == IDLE) && !rst;
    assign req0Ready = idle_ok && req0Valid && !grant;
    assign req1Ready = idle_ok && req1Valid && grant;
    assign accept    = req0Ready || req1Ready;

    assign owner_rsp_ready = owner_q ? rsp1Ready : rsp0Ready;

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block can infer a latch.
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_out_d    = rsp_out_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_ovf_d    = rsp_ovf_q;
        alu_ope_d    = alu_ope_q;
        alu_in1_d    = alu_in1_q;
        alu_in2_d    = alu_in2_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = EXEC;
                    owner_d      = grant;
                    last_grant_d = grant;
                    alu_ope_d    = grant ? req1Ope : req0Ope;
                    alu_in1_d    = grant ? req1In1 : req0In1;
                    alu_in2_d    = grant ? req1In2 : req0In2;
                end
            end
            EXEC: begin
                state_d              = RESP;
                rsp_out_d            = aluOut;
                rsp_zero_d           = aluZero;
                rsp_ovf_d            = aluOverflow;
                rsp_valid_d[owner_q] = 1'b1;
            end
            RESP: begin
                // The non-owner's rspReady is deliberately not looked at here.
                if (owner_rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 2'b00;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 2'b00;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 2'b00;
            rsp_out_q    <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            alu_ope_q    <= '0;
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_out_q    <= rsp_out_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_ovf_q    <= rsp_ovf_d;
            alu_ope_q    <= alu_ope_d;
            alu_in1_q    <= alu_in1_d;
            alu_in2_q    <= alu_in2_d;
        end
    end

    assign rsp0Valid   = rsp_valid_q[0];
    assign rsp1Valid   = rsp_valid_q[1];
    assign rspOut      = rsp_out_q;
    assign rspZero     = rsp_zero_q;
    assign rspOverflow = rsp_ovf_q;
    assign aluOpe      = alu_ope_q;
    assign aluIn1      = alu_in1_q;
    assign aluIn2      = alu_in2_q;

`ifdef ALU_SHARE_ARB_STATS_EN
    logic [15:0] grant_cnt0_q, grant_cnt0_d;
    logic [15:0] grant_cnt1_q, grant_cnt1_d;

    always_comb begin
        grant_cnt0_d = grant_cnt0_q;
        grant_cnt1_d = grant_cnt1_q;
        if (req0Ready && (grant_cnt0_q != 16'hFFFF)) begin
            grant_cnt0_d = grant_cnt0_q + 16'd1;
        end
        if (req1Ready && (grant_cnt1_q != 16'hFFFF)) begin
            grant_cnt1_d = grant_cnt1_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0_q <= 16'd0;
            grant_cnt1_q <= 16'd0;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign grantCnt0 = grant_cnt0_q;
    assign grantCnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: a behavioural ALU feeds the DUT, expected results are queued
// per requester at issue time, and a negedge monitor checks handshakes, results and held ALU inputs.
module tb_alu_share_arb;

    typedef struct {
        logic [31:0] out;
        logic        zero;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  rsp_ready;
    logic [3:0]  req_ope [2];
    logic [31:0] req_in1 [2];
    logic [31:0] req_in2 [2];
    logic        r0_ready, r1_ready, v0, v1;
    logic [31:0] rsp_out;
    logic        rsp_zero, rsp_ovf;
    logic [3:0]  alu_ope;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic        alu_zero, alu_ovf;
    exp_t        alu_r;
`ifdef ALU_SHARE_ARB_STATS_EN
    logic [15:0] gc0, gc1;
    int          st_cnt [2];
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q0[$];
    exp_t q1[$];
    bit   rand_rsp;
    int   handled [2];
    int   acc_cnt [2];

    // Reference model state: outstanding operation, its age in cycles, owner and last grant.
    bit          busy;
    int          age;
    int          owner;
    int          last;
    logic [3:0]  m_ope;
    logic [31:0] m_in1, m_in2;
    logic [1:0]  er, ev;
    exp_t        head;

    always #5 clk = ~clk;

    // Opcodes: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, anything else yields 0.
    function automatic exp_t alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        r;
        logic [31:0] s;
        r.ovf = 1'b0;
        case (op)
            4'd0: s = a & b;
            4'd1: s = a | b;
            4'd2: begin
                s     = a + b;
                r.ovf = (a[31] == b[31]) && (s[31] != a[31]);
            end
            4'd3: begin
                s     = a - b;
                r.ovf = (a[31] != b[31]) && (s[31] != a[31]);
            end
            4'd4: s = a ^ b;
            default: s = 32'd0;
        endcase
        r.out  = s;
        r.zero = (s == 32'd0);
        return r;
    endfunction

    assign alu_r    = alu_ref(alu_ope, alu_in1, alu_in2);
    assign alu_out  = alu_r.out;
    assign alu_zero = alu_r.zero;
    assign alu_ovf  = alu_r.ovf;

    alu_share_arb dut (
        .clk         (clk),
        .rst         (rst),
        .req0Valid   (req_valid[0]),
        .req0Ready   (r0_ready),
        .req0Ope     (req_ope[0]),
        .req0In1     (req_in1[0]),
        .req0In2     (req_in2[0]),
        .req1Valid   (req_valid[1]),
        .req1Ready   (r1_ready),
        .req1Ope     (req_ope[1]),
        .req1In1     (req_in1[1]),
        .req1In2     (req_in2[1]),
        .rsp0Valid   (v0),
        .rsp0Ready   (rsp_ready[0]),
        .rsp1Valid   (v1),
        .rsp1Ready   (rsp_ready[1]),
        .rspOut      (rsp_out),
        .rspZero     (rsp_zero),
        .rspOverflow (rsp_ovf),
        .aluOpe      (alu_ope),
        .aluIn1      (alu_in1),
        .aluIn2      (alu_in2),
        .aluOut      (alu_out),
        .aluZero     (alu_zero),
        .aluOverflow (alu_ovf)
`ifdef ALU_SHARE_ARB_STATS_EN
        ,
        .grantCnt0   (gc0),
        .grantCnt1   (gc1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid[i] = 1'b1;
        req_ope[i]   = op;
        req_in1[i]   = a;
        req_in2[i]   = b;
        if (i == 0) q0.push_back(alu_ref(op, a, b));
        else        q1.push_back(alu_ref(op, a, b));
    endtask

    // Advance one cycle; requesters whose request was taken at this edge drop valid.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (acc_cnt[i] != handled[i]) begin
                req_valid[i] = 1'b0;
                handled[i]   = acc_cnt[i];
            end
        end
        if (rand_rsp) rsp_ready = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((req_valid != 2'b00 || q0.size() != 0 || q1.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("wait_idle_budget_left", 32'(n < budget), 32'd1);
    endtask

    // Monitor / scoreboard: samples on the falling edge, away from the active edge.
    initial begin
        busy = 1'b0; age = 0; owner = 0; last = 1;
        m_ope = '0; m_in1 = '0; m_in2 = '0;
        acc_cnt[0] = 0; acc_cnt[1] = 0;
`ifdef ALU_SHARE_ARB_STATS_EN
        st_cnt[0] = 0; st_cnt[1] = 0;
`endif
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_req0Ready", 32'(r0_ready), 32'd0);
                check("rst_req1Ready", 32'(r1_ready), 32'd0);
                check("rst_rsp0Valid", 32'(v0), 32'd0);
                check("rst_rsp1Valid", 32'(v1), 32'd0);
                check("rst_rspOut", rsp_out, 32'd0);
                check("rst_flags", 32'({rsp_zero, rsp_ovf}), 32'd0);
                check("rst_aluOpe", 32'(alu_ope), 32'd0);
                check("rst_aluIn", alu_in1 | alu_in2, 32'd0);
                busy = 1'b0; age = 0; owner = 0; last = 1;
                m_ope = '0; m_in1 = '0; m_in2 = '0;
                q0.delete();
                q1.delete();
`ifdef ALU_SHARE_ARB_STATS_EN
                st_cnt[0] = 0; st_cnt[1] = 0;
`endif
            end else begin
                for (int i = 0; i < 2; i++) begin
                    er[i] = !busy && req_valid[i] && (!req_valid[1-i] || last != i);
                    ev[i] = busy && age >= 2 && owner == i;
                end
                check("req0Ready", 32'(r0_ready), 32'(er[0]));
                check("req1Ready", 32'(r1_ready), 32'(er[1]));
                check("rsp0Valid", 32'(v0), 32'(ev[0]));
                check("rsp1Valid", 32'(v1), 32'(ev[1]));
                check("aluOpe_held", 32'(alu_ope), 32'(m_ope));
                check("aluIn1_held", alu_in1, m_in1);
                check("aluIn2_held", alu_in2, m_in2);
`ifdef ALU_SHARE_ARB_STATS_EN
                check("grantCnt0", 32'(gc0), 32'(st_cnt[0]));
                check("grantCnt1", 32'(gc1), 32'(st_cnt[1]));
`endif
                if (ev != 2'b00) begin
                    check("scoreboard_has_entry", 32'((owner == 0) ? q0.size() : q1.size()) != 0 ? 32'd1 : 32'd0, 32'd1);
                    if ((owner == 0 && q0.size() != 0) || (owner == 1 && q1.size() != 0)) begin
                        head = (owner == 0) ? q0[0] : q1[0];
                        check("rspOut", rsp_out, head.out);
                        check("rspZero", 32'(rsp_zero), 32'(head.zero));
                        check("rspOverflow", 32'(rsp_ovf), 32'(head.ovf));
                        if (rsp_ready[owner]) begin
                            if (owner == 0) void'(q0.pop_front());
                            else            void'(q1.pop_front());
                        end
                    end
                end
                if (er != 2'b00) begin
                    owner = er[1] ? 1 : 0;
                    last  = owner;
                    busy  = 1'b1;
                    age   = 1;
                    m_ope = req_ope[owner];
                    m_in1 = req_in1[owner];
                    m_in2 = req_in2[owner];
                    acc_cnt[owner]++;
`ifdef ALU_SHARE_ARB_STATS_EN
                    if (st_cnt[owner] < 65535) st_cnt[owner]++;
`endif
                end else if (busy) begin
                    if (age >= 2 && rsp_ready[owner]) busy = 1'b0;
                    else age++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b;
        int          k;
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        rand_rsp  = 1'b0;
        handled[0] = 0; handled[1] = 0;
        for (int i = 0; i < 2; i++) begin
            req_ope[i] = '0; req_in1[i] = '0; req_in2[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Tie from reset: req0 first, then req1; the following tie returns to req0.
        rsp_ready = 2'b11;
        issue(0, 4'd1, 32'h0000_0000, 32'h0000_0000);
        issue(1, 4'd1, 32'h1234_0000, 32'h0000_5678);
        wait_idle(50);
        issue(0, 4'd2, 32'h7FFF_FFFF, 32'h0000_0001);
        issue(1, 4'd3, 32'h8000_0000, 32'h0000_0001);
        wait_idle(50);

        // Single requester AND.
        issue(0, 4'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        wait_idle(50);

        // Backpressure on rsp0 while req1 waits; rsp1Ready high must be ignored.
        rsp_ready = 2'b10;
        issue(0, 4'd4, 32'hDEAD_BEEF, 32'h0F0F_0F0F);
        tick();
        issue(1, 4'd2, 32'h0000_0010, 32'h0000_0020);
        repeat (6) tick();
        rsp_ready = 2'b11;
        wait_idle(50);

        // Unsupported opcode passes through.
        issue(1, 4'hF, 32'h1357_9BDF, 32'h2468_ACE0);
        wait_idle(50);

        // Reset while the operation is in EXEC.
        issue(0, 4'd2, 32'h0000_0005, 32'h0000_0007);
        tick();
        tick();
        rst = 1'b1;
        #1 check("rst_in_exec_rsp0Valid", 32'(v0), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Reset while the response is being held.
        rsp_ready = 2'b00;
        issue(1, 4'd3, 32'h0000_0009, 32'h0000_0004);
        tick();
        tick();
        tick();
        check("resp_before_rst_rsp1Valid", 32'(v1), 32'd1);
        #2 rst = 1'b1;
        #1 check("rst_in_resp_rsp1Valid", 32'(v1), 32'd0);
        tick();
        rst = 1'b0;

        // Tie after reset goes to req0 again.
        rsp_ready = 2'b11;
        issue(0, 4'd4, 32'hAAAA_0000, 32'h0000_5555);
        issue(1, 4'd0, 32'hFFFF_0000, 32'h00FF_FF00);
        wait_idle(50);

        // Randomized traffic with random response backpressure and occasional withdrawals.
        rand_rsp = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 99) < 45) begin
                        k = int'($urandom_range(0, 6));
                        a = $urandom;
                        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
                        issue(i, (k == 6) ? 4'hF : 4'(k), a, b);
                    end
                end else if ($urandom_range(0, 99) < 4) begin
                    req_valid[i] = 1'b0;
                    if (i == 0) void'(q0.pop_back());
                    else        void'(q1.pop_back());
                end
            end
        end
        rand_rsp  = 1'b0;
        rsp_ready = 2'b11;
        wait_idle(100);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Two-requester controller that time-shares one combinational 32-bit CPU ALU (4-bit opcode; result, zero and overflow outputs).
- Each requester has a valid/ready request channel and a valid/ready response channel; the block arbitrates round-robin.
- Operands and opcode are registered before they are driven into the ALU, and the ALU result is registered and held until the owning requester accepts it.
- Sits between the issue logic (requester 0: integer pipe, requester 1: address/aux unit) and the ALU instance.

Parameters:
- ALUOpeLen, 4, ALU opcode width.
- DataWidth, 32, operand/result width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req0Valid / req1Valid  input  1  request present.
- req0Ready / req1Ready  output  1  request accepted this cycle.
- req0Ope / req1Ope  input  ALUOpeLen  opcode.
- req0In1, req0In2 / req1In1, req1In2  input  DataWidth  operands.
- rsp0Valid / rsp1Valid  output  1  result available.
- rsp0Ready / rsp1Ready  input  1  requester takes result.
- rspOut  output  DataWidth  registered ALU result, shared by both requesters.
- rspZero, rspOverflow  output  1  registered ALU flags.
- aluOpe  output  ALUOpeLen  to ALU.
- aluIn1, aluIn2  output  DataWidth  to ALU.
- aluOut  input  DataWidth  from ALU.
- aluZero, aluOverflow  input  1  from ALU.

Behaviour:
- FSM with states IDLE, EXEC, RESP; reset state is IDLE.
- Reset values: req*Ready=0, rsp*Valid=0, rspOut=0, rspZero=0, rspOverflow=0, aluOpe=0, aluIn1=0, aluIn2=0, owner=0, lastGrant=1 (so requester 0 wins the first tie).
- IDLE, grant selection:
  - Only one reqValid high: that requester is granted.
  - Both high: the requester != lastGrant is granted.
  - Neither high: stay in IDLE.
- IDLE, handshake:
  - reqReady is combinational and asserted only in IDLE, only for the granted requester.
  - Accept = valid & ready.
  - On accept: latch opcode and operands into aluOpe/aluIn1/aluIn2, owner=grant, lastGrant=grant, go to EXEC.
- EXEC (exactly 1 cycle):
  - ALU inputs are stable all cycle.
  - At the edge: rspOut<=aluOut, rspZero<=aluZero, rspOverflow<=aluOverflow, rsp[owner]Valid<=1, go to RESP.
- RESP:
  - rsp[owner]Valid stays high and rspOut/flags stay constant until rsp[owner]Ready=1.
  - The cycle after that handshake, rspValid drops and the FSM returns to IDLE.
  - No new request is accepted in RESP; the non-owner's rspReady is ignored.
- Latency: request accepted at edge N, rspValid high from cycle N+2. Minimum issue interval is 3 cycles when rspReady is held high.
- aluIn*/aluOpe hold their last values outside EXEC; no toggling while idle.
- Opcode is passed through unchecked. Unsupported opcodes produce whatever the ALU returns (0), with flags as given by the ALU.
- Requester dropping reqValid before ready: no effect; nothing is latched.
- Async reset mid-EXEC or mid-RESP:
  - The in-flight operation is discarded and rspValid drops immediately.
  - After reset deassertion the FSM is in IDLE and the tie-break restarts at requester 0.
- Starvation bound: with both requesters continuously valid, grants strictly alternate 0,1,0,1.

Optional Feature:
- ALU_SHARE_ARB_STATS_EN.
- Defined: adds outputs grantCnt0 and grantCnt1 (16 bits each).
  - Each increments on its requester's request accept and saturates at 0xFFFF.
  - Both reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Req0 only: Ope=0000, In1=0xF0F0F0F0, In2=0x0FF00FF0, rsp0Ready=1 -> rsp0Valid high 2 cycles after accept, rspOut=0x00F000F0, rsp1Valid stays 0.
2. Both valid from reset: req0 OR (0001) of 0x00000000|0x00000000, req1 OR 0x12340000|0x00005678 -> req0 granted first (rspOut=0, rspZero=1), then req1 (rspOut=0x12345678, rspZero=0); next tie goes to req0.
3. Backpressure: rsp0Ready=0 for 5 cycles in RESP -> rsp0Valid and rspOut stable; req1Valid held high gets no ready until 1 cycle after the rsp0 handshake.
4. Unsupported opcode 1111 -> rspOut=0; flags equal the ALU's flag outputs; FSM completes normally.
5. Assert rst during EXEC -> rspValid=0 immediately, no response is ever produced for that operation, and after release the next tie goes to req0.
6. (STATS_EN) 70000 accepts on req0 -> grantCnt0=0xFFFF, grantCnt1=0.
